// File: rtl/id_stage_reg.sv
// -----------------------------------------------------------------------------
// id_stage_reg
//
// Pipeline register between instruction decode (ID) and execute (EX) of the
// 5-stage ARM core. Each cycle it captures the decoded control bits, operand
// values, register indices, immediates, the current carry flag and a valid bit.
//
// Per rising edge, highest priority first:
//   flush  : load an all-zero bubble (taken branch in EX kills this slot)
//   freeze : hold every field, including carry_out and valid_out (memory stall)
//   load   : take every *_in, carry_out <= status_register[1], valid_out <= valid_in
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   freeze, flush               stall / squash controls
//   valid_in                    ID slot holds a real instruction
//   wb_en_in .. sr_update_in    decoded control bits
//   ex_command_in               ALU command (4 bits)
//   status_register             current flags {N,Z,C,V}; only C is captured
//   pc_in, val_rn_in, val_rm_in WORD_WIDTH datapath values
//   src1_in, src2_in, dst_in    register indices
//   signed_imm_in               branch offset (no sign extension here)
//   shifter_operand_in          operand-2 field
//   *_out                       registered copies; carry_out, valid_out
// -----------------------------------------------------------------------------
module id_stage_reg #(
    parameter int WORD_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int IMM_WIDTH      = 24,
    parameter int SHIFTER_WIDTH  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic                      wb_en_in,
    input  logic                      mem_read_in,
    input  logic                      mem_write_in,
    input  logic                      imm_in,
    input  logic                      b_in,
    input  logic                      sr_update_in,
    input  logic [3:0]                ex_command_in,
    input  logic [3:0]                status_register,
    input  logic [WORD_WIDTH-1:0]     pc_in,
    input  logic [WORD_WIDTH-1:0]     val_rn_in,
    input  logic [WORD_WIDTH-1:0]     val_rm_in,
    input  logic [REG_ADDR_WIDTH-1:0] src1_in,
    input  logic [REG_ADDR_WIDTH-1:0] src2_in,
    input  logic [REG_ADDR_WIDTH-1:0] dst_in,
    input  logic [IMM_WIDTH-1:0]      signed_imm_in,
    input  logic [SHIFTER_WIDTH-1:0]  shifter_operand_in,
    output logic                      wb_en_out,
    output logic                      mem_read_out,
    output logic                      mem_write_out,
    output logic                      imm_out,
    output logic                      b_out,
    output logic                      sr_update_out,
    output logic [3:0]                ex_command_out,
    output logic [WORD_WIDTH-1:0]     pc_out,
    output logic [WORD_WIDTH-1:0]     val_rn_out,
    output logic [WORD_WIDTH-1:0]     val_rm_out,
    output logic [REG_ADDR_WIDTH-1:0] src1_out,
    output logic [REG_ADDR_WIDTH-1:0] src2_out,
    output logic [REG_ADDR_WIDTH-1:0] dst_out,
    output logic [IMM_WIDTH-1:0]      signed_imm_out,
    output logic [SHIFTER_WIDTH-1:0]  shifter_operand_out,
    output logic                      carry_out,
    output logic                      valid_out
);

    // All fields travel as one flat bundle so that flush/freeze/load apply to
    // every bit identically. Field order is fixed by the pack/unpack below.
    localparam int BUNDLE_W = 6 + 4 + 3 * WORD_WIDTH + 3 * REG_ADDR_WIDTH
                            + IMM_WIDTH + SHIFTER_WIDTH + 2;

    logic [BUNDLE_W-1:0] bundle_in;
    logic [BUNDLE_W-1:0] bundle_reg;
    logic [BUNDLE_W-1:0] bundle_next;

    assign bundle_in = {
        wb_en_in, mem_read_in, mem_write_in, imm_in, b_in, sr_update_in,
        ex_command_in,
        pc_in, val_rn_in, val_rm_in,
        src1_in, src2_in, dst_in,
        signed_imm_in, shifter_operand_in,
        status_register[1],   // carry flag for the instruction entering EX
        valid_in
    };

    // Only the C flag is captured; the other flags are consumed elsewhere.
    logic unused_flags;
    assign unused_flags = ^{status_register[3:2], status_register[0]};

    // flush beats freeze so the instruction behind a taken branch dies even
    // while the pipeline is stalled.
    always_comb begin
        bundle_next = bundle_reg;
        if (flush) begin
            bundle_next = '0;
        end else if (!freeze) begin
            bundle_next = bundle_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_reg <= '0;
        end else begin
            bundle_reg <= bundle_next;
        end
    end

    assign {
        wb_en_out, mem_read_out, mem_write_out, imm_out, b_out, sr_update_out,
        ex_command_out,
        pc_out, val_rn_out, val_rm_out,
        src1_out, src2_out, dst_out,
        signed_imm_out, shifter_operand_out,
        carry_out,
        valid_out
    } = bundle_reg;

endmodule

// File: tb/tb_id_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_stage_reg
//
// Directed plus randomized bench for id_stage_reg. Each driven cycle computes
// the expected register contents from the stimulus and pushes them to a
// scoreboard queue; one edge later the entry is popped and compared field by
// field against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_id_stage_reg;

    typedef struct packed {
        logic        wb_en;
        logic        mem_read;
        logic        mem_write;
        logic        imm;
        logic        b;
        logic        sr_update;
        logic [3:0]  ex_command;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  dst;
        logic [23:0] signed_imm;
        logic [11:0] shifter_operand;
        logic        carry;
        logic        valid;
    } fields_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       freeze = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] status_register = 4'h0;
    fields_t    drv = '0;   // .carry is not driven to the DUT; C comes from status_register
    fields_t    obs;
    fields_t    exp_state = '0;
    fields_t    sb_q[$];

    int checks = 0;
    int errors = 0;

    logic        wb_en_out, mem_read_out, mem_write_out, imm_out, b_out, sr_update_out;
    logic [3:0]  ex_command_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [3:0]  src1_out, src2_out, dst_out;
    logic [23:0] signed_imm_out;
    logic [11:0] shifter_operand_out;
    logic        carry_out, valid_out;

    always #5 clk = ~clk;

    id_stage_reg dut (
        .clk                 (clk),
        .rst                 (rst),
        .freeze              (freeze),
        .flush               (flush),
        .valid_in            (drv.valid),
        .wb_en_in            (drv.wb_en),
        .mem_read_in         (drv.mem_read),
        .mem_write_in        (drv.mem_write),
        .imm_in              (drv.imm),
        .b_in                (drv.b),
        .sr_update_in        (drv.sr_update),
        .ex_command_in       (drv.ex_command),
        .status_register     (status_register),
        .pc_in               (drv.pc),
        .val_rn_in           (drv.val_rn),
        .val_rm_in           (drv.val_rm),
        .src1_in             (drv.src1),
        .src2_in             (drv.src2),
        .dst_in              (drv.dst),
        .signed_imm_in       (drv.signed_imm),
        .shifter_operand_in  (drv.shifter_operand),
        .wb_en_out           (wb_en_out),
        .mem_read_out        (mem_read_out),
        .mem_write_out       (mem_write_out),
        .imm_out             (imm_out),
        .b_out               (b_out),
        .sr_update_out       (sr_update_out),
        .ex_command_out      (ex_command_out),
        .pc_out              (pc_out),
        .val_rn_out          (val_rn_out),
        .val_rm_out          (val_rm_out),
        .src1_out            (src1_out),
        .src2_out            (src2_out),
        .dst_out             (dst_out),
        .signed_imm_out      (signed_imm_out),
        .shifter_operand_out (shifter_operand_out),
        .carry_out           (carry_out),
        .valid_out           (valid_out)
    );

    assign obs = {wb_en_out, mem_read_out, mem_write_out, imm_out, b_out, sr_update_out,
                  ex_command_out, pc_out, val_rn_out, val_rm_out,
                  src1_out, src2_out, dst_out, signed_imm_out, shifter_operand_out,
                  carry_out, valid_out};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic cmp_all(input string step, input fields_t o, input fields_t e);
        chk({step, ".wb_en"},      32'(o.wb_en),      32'(e.wb_en));
        chk({step, ".mem_read"},   32'(o.mem_read),   32'(e.mem_read));
        chk({step, ".mem_write"},  32'(o.mem_write),  32'(e.mem_write));
        chk({step, ".imm"},        32'(o.imm),        32'(e.imm));
        chk({step, ".b"},          32'(o.b),          32'(e.b));
        chk({step, ".sr_update"},  32'(o.sr_update),  32'(e.sr_update));
        chk({step, ".ex_command"}, 32'(o.ex_command), 32'(e.ex_command));
        chk({step, ".pc"},         o.pc,              e.pc);
        chk({step, ".val_rn"},     o.val_rn,          e.val_rn);
        chk({step, ".val_rm"},     o.val_rm,          e.val_rm);
        chk({step, ".src1"},       32'(o.src1),       32'(e.src1));
        chk({step, ".src2"},       32'(o.src2),       32'(e.src2));
        chk({step, ".dst"},        32'(o.dst),        32'(e.dst));
        chk({step, ".signed_imm"}, 32'(o.signed_imm), 32'(e.signed_imm));
        chk({step, ".shifter"},    32'(o.shifter_operand), 32'(e.shifter_operand));
        chk({step, ".carry"},      32'(o.carry),      32'(e.carry));
        chk({step, ".valid"},      32'(o.valid),      32'(e.valid));
    endtask

    // Apply freeze/flush for one edge: update the reference state from the
    // stimulus, queue it, then compare after the edge.
    task automatic step(input string name, input logic fr, input logic fl);
        fields_t e;
        freeze = fr;
        flush  = fl;
        if (fl) begin
            exp_state = '0;
        end else if (!fr) begin
            exp_state       = drv;
            exp_state.carry = status_register[1];
        end
        sb_q.push_back(exp_state);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        cmp_all(name, obs, e);
        $display("step %-10s fr=%0b fl=%0b pc_out=%08h valid_out=%0b", name, fr, fl, pc_out, valid_out);
    endtask

    initial begin
        logic [159:0] rnd;
        fields_t      ones;
        string        nm;

        // Reset held from time 0 across two edges
        repeat (2) @(posedge clk);
        #1;
        cmp_all("por", obs, '0);
        @(negedge clk);
        rst = 1'b0;

        // Load all-ones, then assert reset mid-cycle while freeze and flush are high
        ones = '1;
        drv = ones;
        status_register = 4'hF;
        step("ones", 1'b0, 1'b0);
        #2;
        freeze = 1'b1;
        flush  = 1'b1;
        rst    = 1'b1;
        #1;
        cmp_all("async_rst", obs, '0);
        @(posedge clk);
        #1;
        cmp_all("rst_hold", obs, '0);
        @(negedge clk);
        rst = 1'b0;
        freeze = 1'b0;
        flush = 1'b0;
        exp_state = '0;

        // First load after reset
        drv = '0;
        status_register = 4'h0;
        drv.pc = 32'h0000_0008;
        drv.valid = 1'b1;
        step("pc8", 1'b0, 1'b0);

        // Basic load with carry capture
        drv = '0;
        drv.val_rn = 32'h1234_5678;
        drv.ex_command = 4'b0010;
        drv.wb_en = 1'b1;
        drv.valid = 1'b1;
        status_register = 4'b0010;
        step("load", 1'b0, 1'b0);
        chk("load.carry_direct", 32'(carry_out), 32'd1);

        // Freeze for three cycles while pc_in moves, then release
        drv.pc = 32'h10;
        status_register = 4'b0000;
        step("frz_ld", 1'b0, 1'b0);
        drv.pc = 32'h14; status_register = 4'b0010; drv.valid = 1'b0;
        step("frz1", 1'b1, 1'b0);
        drv.pc = 32'h18;
        step("frz2", 1'b1, 1'b0);
        drv.pc = 32'h1C; drv.valid = 1'b1;
        step("frz3", 1'b1, 1'b0);
        chk("frz.pc_held", pc_out, 32'h10);
        step("frz_rel", 1'b0, 1'b0);
        chk("frz.pc_rel", pc_out, 32'h1C);

        // Flush after a store-with-writeback loads
        drv.wb_en = 1'b1;
        drv.mem_write = 1'b1;
        drv.pc = 32'h24;
        step("fl_ld", 1'b0, 1'b0);
        drv.pc = 32'h28;
        step("flush", 1'b0, 1'b1);
        chk("flush.invariant",
            32'({valid_out, wb_en_out, mem_write_out, mem_read_out, b_out, sr_update_out}), 32'd0);
        step("fl_next", 1'b0, 1'b0);

        // Flush and freeze together: flush wins, then freeze holds the bubble
        drv.pc = 32'h20;
        drv.b = 1'b1;
        step("ff_ld", 1'b0, 1'b0);
        drv.pc = 32'h30;
        step("ff_both", 1'b1, 1'b1);
        step("ff_hold", 1'b1, 1'b0);

        // Bubble pass-through: controls zero, datapath still loaded
        drv = '0;
        drv.src1 = 4'hA;
        drv.valid = 1'b0;
        status_register = 4'b0010;
        step("bubble", 1'b0, 1'b0);
        chk("bubble.src1", 32'(src1_out), 32'hA);

        // Randomized loads with occasional freeze/flush
        for (int i = 0; i < 24; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            drv = rnd[$bits(fields_t)-1:0];
            status_register = 4'($urandom);
            nm = $sformatf("rnd%0d", i);
            step(nm, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
